// File: rtl/ras_call_detect.sv
// rtl/ras_call_detect.sv - call/return classifier and stage tag tracker feeding the return address stack
module ras_call_detect #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 31
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              out_pred_valid,
    output logic [31:0]       out_pred_target,
    output logic              ras_push,
    output logic              ras_pop,
    output logic [WIDTH-1:0]  ras_din,
    input  logic [WIDTH-1:0]  ras_dout,
    input  logic              ras_valid,
    input  logic [STAGES-1:0] stage_adv,
    input  logic [STAGES-1:0] stage_kill,
    output logic [STAGES-1:0] ras_commit,
    output logic [STAGES-1:0] ras_flush
);

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [2:0]        funct3;
    logic              is_jal;
    logic              is_jalr;
    logic              rd_link;
    logic              rs1_link;
    logic              cls_push;
    logic              cls_pop;
    logic              in_fire;
    logic              out_fire;
    logic              any_kill;
    logic [31:0]       next_pc;
    logic              out_tag;
    logic [STAGES-1:0] tag;
    logic [STAGES-1:0] tag_next;
    logic [STAGES-1:0] kill_mask;

    // Decode the instruction fields and classify it as push, pop or both
    always_comb begin
        opcode   = in_instr[6:0];
        rd       = in_instr[11:7];
        funct3   = in_instr[14:12];
        rs1      = in_instr[19:15];
        is_jal   = (opcode == OPC_JAL);
        is_jalr  = (opcode == OPC_JALR) && (funct3 == 3'b000);
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
        // Every linking jump pushes; a JALR through a link register pops
        // unless it is the same register (which is a plain call).
        cls_push = (is_jal || is_jalr) && rd_link;
        cls_pop  = is_jalr && rs1_link && (!rd_link || (rd != rs1));
    end

    assign any_kill = |stage_kill;
    assign in_ready = !rst_i && !any_kill && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign next_pc  = in_pc + 32'd4;
    assign ras_din  = next_pc[31:1];
    assign ras_push = cls_push && in_fire;
    assign ras_pop  = cls_pop && in_fire;

    assign ras_flush = stage_kill;

    // kill_mask[i]: stage i is squashed by a kill at stage i or any older stage
    always_comb begin
        kill_mask = '0;
        kill_mask[STAGES-1] = stage_kill[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            kill_mask[i] = kill_mask[i+1] || stage_kill[i];
        end
    end

    // A tagged stage that advances and survives commits its stack operation
    always_comb begin
        ras_commit = '0;
        for (int i = 0; i < STAGES; i++) begin
            ras_commit[i] = !rst_i && stage_adv[i] && tag[i] && !kill_mask[i];
        end
    end

    // Tag conveyor: each stage takes its older neighbour's tag on advance, squashed stages clear
    always_comb begin
        tag_next = tag;
        if (out_fire) begin
            tag_next[0] = out_tag;
        end else if (stage_adv[0]) begin
            tag_next[0] = 1'b0;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (stage_adv[i-1]) begin
                tag_next[i] = tag[i-1] && !kill_mask[i-1];
            end else if (stage_adv[i]) begin
                tag_next[i] = 1'b0;
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            if (kill_mask[i]) begin
                tag_next[i] = 1'b0;
            end
        end
    end

    // Stage tag register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tag <= '0;
        end else begin
            tag <= tag_next;
        end
    end

    // Out register: load on accept, drain on out_ready, hold under backpressure, clear on kill
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_valid       <= 1'b0;
            out_tag         <= 1'b0;
            out_pc          <= '0;
            out_instr       <= '0;
            out_pred_valid  <= 1'b0;
            out_pred_target <= '0;
        end else if (any_kill) begin
            out_valid <= 1'b0;
            out_tag   <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_tag   <= cls_push || cls_pop;
            out_pc    <= in_pc;
            out_instr <= in_instr;
            // ras_dout still shows the top before this cycle's pop takes effect
            if (cls_pop) begin
                out_pred_valid  <= ras_valid;
                out_pred_target <= {ras_dout, 1'b0};
            end else begin
                out_pred_valid  <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_tag   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ras_call_detect.sv
// tb/tb_ras_call_detect.sv - directed self-checking bench for ras_call_detect
module tb_ras_call_detect;

    localparam logic [31:0] I_JAL_X1    = 32'h008000EF;
    localparam logic [31:0] I_RET       = 32'h00008067;
    localparam logic [31:0] I_JALR_5_1  = 32'h000082E7;
    localparam logic [31:0] I_JALR_1_1  = 32'h000080E7;
    localparam logic [31:0] I_JALR_2_3  = 32'h00018167;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred_valid;
    logic [31:0] out_pred_target;
    logic        ras_push;
    logic        ras_pop;
    logic [30:0] ras_din;
    logic [30:0] ras_dout;
    logic        ras_valid;
    logic [1:0]  stage_adv;
    logic [1:0]  stage_kill;
    logic [1:0]  ras_commit;
    logic [1:0]  ras_flush;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ras_call_detect #(.STAGES(2), .WIDTH(31)) dut (
        .clk(clk), .rst_i(rst_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_valid(out_pred_valid), .out_pred_target(out_pred_target),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din),
        .ras_dout(ras_dout), .ras_valid(ras_valid),
        .stage_adv(stage_adv), .stage_kill(stage_kill),
        .ras_commit(ras_commit), .ras_flush(ras_flush)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
    endtask

    initial begin
        rst_i = 1'b1; out_ready = 1'b1; ras_dout = '0; ras_valid = 1'b0;
        stage_adv = '0; stage_kill = '0;
        drive(1'b1, 32'h1000, I_JAL_X1);
        tick(); tick();
        // reset state; flush passes through even in reset
        stage_kill = 2'b10;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pred_valid", {31'd0, out_pred_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_push", {31'd0, ras_push}, 32'd0);
        chk("rst_flush", {30'd0, ras_flush}, 32'd2);
        stage_kill = 2'b00;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        // call: first accept right after reset falls
        chk("call_push", {31'd0, ras_push}, 32'd1);
        chk("call_pop", {31'd0, ras_pop}, 32'd0);
        chk("call_din", {1'b0, ras_din}, 32'h802);
        tick();
        chk("call_out_valid", {31'd0, out_valid}, 32'd1);
        chk("call_out_pc", out_pc, 32'h1000);
        chk("call_pred_valid", {31'd0, out_pred_valid}, 32'd0);

        // return
        drive(1'b1, 32'h2000, I_RET);
        ras_dout = 31'h802; ras_valid = 1'b1;
        #1;
        chk("ret_pop", {31'd0, ras_pop}, 32'd1);
        chk("ret_push", {31'd0, ras_push}, 32'd0);
        tick();
        chk("ret_pred_valid", {31'd0, out_pred_valid}, 32'd1);
        chk("ret_pred_target", out_pred_target, 32'h1004);
        chk("ret_out_instr", out_instr, I_RET);

        // swap
        drive(1'b1, 32'h3000, I_JALR_5_1);
        #1;
        chk("swap_push", {31'd0, ras_push}, 32'd1);
        chk("swap_pop", {31'd0, ras_pop}, 32'd1);
        chk("swap_din", {1'b0, ras_din}, 32'h1802);
        tick();
        chk("swap_pred_valid", {31'd0, out_pred_valid}, 32'd1);
        drive(1'b1, 32'h3004, I_JALR_1_1);
        #1;
        chk("same_push", {31'd0, ras_push}, 32'd1);
        chk("same_pop", {31'd0, ras_pop}, 32'd0);
        tick();
        chk("same_pred_valid", {31'd0, out_pred_valid}, 32'd0);
        drive(1'b1, 32'h3008, I_JALR_2_3);
        #1;
        chk("plain_push", {31'd0, ras_push}, 32'd0);
        chk("plain_pop", {31'd0, ras_pop}, 32'd0);
        tick();
        // pc wrap at top of address space
        drive(1'b1, 32'hFFFF_FFFC, I_JAL_X1);
        #1;
        chk("wrap_din", {1'b0, ras_din}, 32'h0);
        tick();

        // untagged instruction through stage 0 gives no commit
        drive(1'b1, 32'h3100, I_JALR_2_3);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        stage_adv = 2'b01;
        #1;
        chk("untagged_commit", {30'd0, ras_commit}, 32'd0);
        tick();
        stage_adv = 2'b00;

        // commit walk
        drive(1'b1, 32'h4000, I_JAL_X1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        tick();
        stage_adv = 2'b01;
        #1;
        chk("commit_s0", {30'd0, ras_commit}, 32'd1);
        tick();
        stage_adv = 2'b10;
        #1;
        chk("commit_s1", {30'd0, ras_commit}, 32'd2);
        tick();
        stage_adv = 2'b11;
        #1;
        chk("commit_empty", {30'd0, ras_commit}, 32'd0);
        tick();
        stage_adv = 2'b00;

        // kill: fill tag[0], tag[1] and out
        drive(1'b1, 32'h5000, I_JAL_X1);
        tick();
        drive(1'b1, 32'h5004, I_JAL_X1);
        tick();
        drive(1'b1, 32'h5008, I_JAL_X1);
        stage_adv = 2'b01;
        #1;
        chk("conveyor_commit", {30'd0, ras_commit}, 32'd1);
        tick();
        stage_adv = 2'b00;
        drive(1'b1, 32'h500C, I_JAL_X1);
        stage_kill = 2'b01;
        #1;
        chk("kill_out_valid_before", {31'd0, out_valid}, 32'd1);
        chk("kill_flush", {30'd0, ras_flush}, 32'd1);
        chk("kill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("kill_push", {31'd0, ras_push}, 32'd0);
        tick();
        stage_kill = 2'b00;
        drive(1'b0, 32'h0, 32'h0);
        stage_adv = 2'b10;
        #1;
        chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
        chk("kill_tag1_kept", {30'd0, ras_commit}, 32'd2);
        tick();
        stage_adv = 2'b01;
        #1;
        chk("kill_tag0_clear", {30'd0, ras_commit}, 32'd0);
        tick();
        stage_adv = 2'b00;

        // backpressure
        drive(1'b1, 32'h6000, I_JAL_X1);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h6100, I_JAL_X1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_push", {31'd0, ras_push}, 32'd0);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_out_pc", out_pc, 32'h6000);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_push", {31'd0, ras_push}, 32'd1);
        tick();
        chk("bp_release_pc", out_pc, 32'h6100);

        // reset mid-stream clears outputs immediately
        rst_i = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_pc", out_pc, 32'd0);
        chk("mid_rst_pred_target", out_pred_target, 32'd0);
        chk("mid_rst_push", {31'd0, ras_push}, 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ras_call_detect.md
# ras_call_detect

Front-end decode stage directly upstream of the return address stack: classifies each fetched RV32 instruction as call, return, or coroutine swap, and drives the stack's push/pop/data inputs. For returns, it attaches the stack's top-of-stack as a predicted target on the forwarded instruction. It also tracks which in-flight pipeline stages carry a stack operation, and turns backend advance/kill events into the stack's per-stage commit and flush vectors.

## Interface
- STAGES, 2, number of speculative pipeline stages tracked; equals the stack's STAGES.
- WIDTH, 31, stack entry width; fixed at 31, holding address bits [31:1].

- clk  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid / in_ready  in / out  1 / 1  fetch handshake.
- in_pc  in  32  instruction address.
- in_instr  in  32  instruction word; uncompressed only.
- out_valid / out_ready  out / in  1 / 1  handshake to decode.
- out_pc, out_instr  out  32, 32  registered copies of in_pc, in_instr.
- out_pred_valid  out  1  out_pred_target is meaningful.
- out_pred_target  out  32  predicted return target.
- ras_push, ras_pop  out  1, 1  stack operation for the current cycle.
- ras_din  out  WIDTH  data pushed onto the stack.
- ras_dout  in  WIDTH  current top of stack.
- ras_valid  in  1  top-of-stack valid.
- stage_adv  in  STAGES  pipeline stage i hands its instruction onward this cycle.
- stage_kill  in  STAGES  stage i and all younger stages (lower index) and the out register are squashed.
- ras_commit, ras_flush  out  STAGES, STAGES  stack commit and flush vectors.

## Operation
- link(r) = (r == x1 || r == x5).
- Fields: rd = instr[11:7], rs1 = instr[19:15].
- Opcode JAL = 7'b1101111; opcode JALR = 7'b1100111 with funct3 = 0.
- Classification:
  - JAL with link(rd): push.
  - JALR, link(rd) and not link(rs1): push.
  - JALR, not link(rd) and link(rs1): pop.
  - JALR, link(rd) and link(rs1), rd != rs1: pop and push.
  - JALR, link(rd) and link(rs1), rd == rs1: push.
  - Anything else: no stack operation.
- in_fire = in_valid && in_ready.
- in_ready = !rst_i && !(|stage_kill) && (!out_valid || out_ready).
- ras_push and ras_pop are combinational: the classification ANDed with in_fire. Both high in the same cycle is legal.
- ras_din = (in_pc + 32'd4)[31:1]. The 32-bit add wraps modulo 2^32.
- Prediction, on an in_fire with pop set:
  - out_pred_target <= {ras_dout, 1'b0}; this is the top before the pop, since ras_dout reflects the previous cycle.
  - out_pred_valid <= ras_valid.
  - Without a pop, out_pred_valid <= 0.
- Out register:
  - On in_fire: loads pc, instr and prediction, and sets out_valid.
  - Else on out_ready: clears out_valid.
  - When out_valid && !out_ready: holds all contents stable.
- Tag pipeline tag[STAGES-1:0], one bit per stage meaning "carries a stack operation":
  - out_tag is set with the out register when the instruction had push or pop.
  - On out_valid && out_ready, out_tag moves to tag[0].
  - On stage_adv[i], tag[i] moves to tag[i+1]. The last stage's tag is dropped.
- ras_commit[i] = stage_adv[i] && tag[i] && !(|stage_kill[STAGES-1:i]).
- ras_flush[i] = stage_kill[i], combinational passthrough.
- stage_kill[i]:
  - Next cycle: tag[0..i], out_tag and out_valid are 0.
  - tag[j] for j > i advances or holds normally.
  - Same-cycle in_fire is impossible because in_ready = 0.

## Timing
- Reset values (asynchronous): out_valid 0, out_pred_valid 0, out_pc/out_instr/out_pred_target 0, all tags 0.
- During reset: in_ready 0, so ras_push/ras_pop/ras_commit are 0. ras_flush still follows stage_kill.
- Latency: in_fire to out_valid is 1 cycle. Stack operations are issued in the accept cycle.
- Throughput: 1 instruction per cycle when out_ready is held high.
- Simultaneous stage_adv[i] and stage_adv[i-1]: tags shift as a conveyor with no loss.
- Stage_adv[i] on an empty (untagged) stage: no commit.
- Reset deasserting mid-stream: the first accept is allowed in the cycle after rst_i falls.

## Test plan
- Call: in_pc = 0x1000, instr = JAL x1 (0x008000EF) -> ras_push = 1, ras_din = 0x802 in the same cycle; out_valid next cycle, out_pred_valid = 0.
- Return: ras_dout = 0x802, ras_valid = 1, instr = JALR x0, 0(x1) (0x00008067) -> ras_pop = 1; next cycle out_pred_target = 0x1004, out_pred_valid = 1.
- Swap: JALR x5, 0(x1) -> push and pop both 1. JALR x1, 0(x1) -> push only. JALR x2, 0(x3) -> neither.
- Commit: tagged instruction leaves out; then stage_adv = 2'b01, then 2'b10 -> ras_commit = 01, then 10, one cycle each.
- Kill: tags in stages 0 and 1, out_valid = 1, stage_kill = 2'b01 -> ras_flush = 01, in_ready = 0; next cycle tag[0] = 0, out_valid = 0, tag[1] retained.
- Backpressure and reset: out_ready = 0 for 3 cycles -> out contents stable, no ras_push. Assert rst_i mid-stream -> all outputs at reset values immediately.
